// File: rtl/tiny_alu.sv
// Tiny16-encoded ALU widened to WIDTH bits, with registered C/Z/N/V flags and optional iterative MUL/DIV.
// Single-cycle ops complete on the accept edge; MUL/DIV take WIDTH busy cycles with in_ready low until done.
module tiny_alu #(
  parameter int WIDTH   = 16,
  parameter int MUL_DIV = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_hi,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  // The final MUL/DIV iteration writes results directly, so in_ready rises with done.
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, hi_q, wk_hi_q, wk_lo_q, opnd_q;
  logic             c_q, z_q, n_q, v_q, done_q, ill_q;

  logic [WIDTH:0]   sum_d, cin_d;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d, wr_acc_d, wr_c_d, wr_v_d, wr_zn_d;
  logic             legal_d, mul_d, div_d, div0_d;

  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] mul_hi, mul_lo, rem_sub, div_hi, div_lo;
  logic             fits, last;

  assign cin_d = {{WIDTH{1'b0}}, c_q & op[0]};

  always_comb begin
    sum_d    = '0;
    res_d    = '0;
    c_d      = c_q;
    v_d      = 1'b0;
    wr_acc_d = 1'b1;
    wr_c_d   = 1'b0;
    wr_v_d   = 1'b1;
    wr_zn_d  = 1'b1;
    legal_d  = 1'b1;
    mul_d    = 1'b0;
    div_d    = 1'b0;
    div0_d   = 1'b0;
    case (op)
      5'd0:  res_d = '0;
      5'd1:  res_d = '1;
      5'd2: begin
        sum_d = {1'b0, a} + ONE;
        res_d = sum_d[WIDTH-1:0];
        v_d   = ~a[WIDTH-1] & res_d[WIDTH-1];
      end
      5'd3: begin
        sum_d = {1'b0, a} - ONE;
        res_d = sum_d[WIDTH-1:0];
        v_d   = a[WIDTH-1] & ~res_d[WIDTH-1];
      end
      5'd4:  res_d = ~a;
      5'd5: begin
        sum_d = '0 - {1'b0, a};
        res_d = sum_d[WIDTH-1:0];
        v_d   = a[WIDTH-1] & res_d[WIDTH-1];
      end
      5'd6:  begin res_d = {a[WIDTH-2:0], 1'b0}; c_d = a[WIDTH-1]; wr_c_d = 1'b1; end
      5'd7:  begin res_d = {1'b0, a[WIDTH-1:1]}; c_d = a[0];       wr_c_d = 1'b1; end
      5'd8:  begin res_d = {a[WIDTH-2:0], c_q};  c_d = a[WIDTH-1]; wr_c_d = 1'b1; end
      5'd9:  begin res_d = {c_q, a[WIDTH-1:1]};  c_d = a[0];       wr_c_d = 1'b1; end
      5'd10, 5'd11: begin
        c_d      = op[0];
        wr_c_d   = 1'b1;
        wr_acc_d = 1'b0;
        wr_v_d   = 1'b0;
        wr_zn_d  = 1'b0;
      end
      5'd12: begin
        if (MUL_DIV != 0) mul_d = 1'b1;
        else              legal_d = 1'b0;
      end
      5'd13: begin
        if (MUL_DIV == 0) legal_d = 1'b0;
        else if (b == '0) begin
          div0_d = 1'b1;
          res_d  = '1;
          c_d    = 1'b0;
          wr_c_d = 1'b1;
          v_d    = 1'b1;
        end else div_d = 1'b1;
      end
      5'd16: res_d = b;
      5'd17, 5'd18: begin
        sum_d  = {1'b0, a} + {1'b0, b} + cin_d;
        res_d  = sum_d[WIDTH-1:0];
        c_d    = sum_d[WIDTH];
        wr_c_d = 1'b1;
        v_d    = (a[WIDTH-1] == b[WIDTH-1]) & (res_d[WIDTH-1] != a[WIDTH-1]);
      end
      5'd19, 5'd20, 5'd30: begin
        sum_d    = {1'b0, a} - {1'b0, b} - cin_d;
        res_d    = sum_d[WIDTH-1:0];
        c_d      = sum_d[WIDTH];
        wr_c_d   = 1'b1;
        wr_acc_d = (op != 5'd30);
        v_d      = (a[WIDTH-1] != b[WIDTH-1]) & (res_d[WIDTH-1] != a[WIDTH-1]);
      end
      5'd21, 5'd31: begin res_d = a & b; wr_acc_d = (op != 5'd31); end
      5'd22: res_d = a | b;
      5'd23: res_d = a ^ b;
      default: legal_d = 1'b0;
    endcase
  end

  // Shift-add multiply: wk_lo holds the multiplier and fills with product low bits.
  assign mul_sum = {1'b0, wk_hi_q} + {1'b0, opnd_q & {WIDTH{wk_lo_q[0]}}};
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], wk_lo_q[WIDTH-1:1]};

  // Restoring divide: wk_hi is the partial remainder, wk_lo shifts dividend out and quotient in.
  assign rem_sh  = {wk_hi_q, wk_lo_q[WIDTH-1]};
  assign fits    = (rem_sh >= {1'b0, opnd_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_hi  = fits ? rem_sub : rem_sh[WIDTH-1:0];
  assign div_lo  = {wk_lo_q[WIDTH-2:0], fits};

  assign last = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      wk_hi_q <= '0;
      wk_lo_q <= '0;
      opnd_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (!legal_d) begin
            done_q <= 1'b1;
            ill_q  <= 1'b1;
          end else if (mul_d) begin
            wk_hi_q <= '0;
            wk_lo_q <= b;
            opnd_q  <= a;
            cnt_q   <= '0;
            state_q <= MUL;
          end else if (div_d) begin
            wk_hi_q <= '0;
            wk_lo_q <= a;
            opnd_q  <= b;
            cnt_q   <= '0;
            state_q <= DIV;
          end else begin
            done_q <= 1'b1;
            if (wr_acc_d) acc_q <= res_d;
            if (div0_d)   hi_q  <= a;
            if (wr_c_d)   c_q   <= c_d;
            if (wr_v_d)   v_q   <= v_d;
            if (wr_zn_d) begin
              z_q <= (res_d == '0);
              n_q <= res_d[WIDTH-1];
            end
          end
        end
        MUL: begin
          wk_hi_q <= mul_hi;
          wk_lo_q <= mul_lo;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            acc_q   <= mul_lo;
            hi_q    <= mul_hi;
            c_q     <= |mul_hi;
            z_q     <= ~|{mul_hi, mul_lo};
            n_q     <= mul_lo[WIDTH-1];
            v_q     <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        DIV: begin
          wk_hi_q <= div_hi;
          wk_lo_q <= div_lo;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            acc_q   <= div_lo;
            hi_q    <= div_hi;
            c_q     <= 1'b0;
            z_q     <= (div_lo == '0);
            n_q     <= div_lo[WIDTH-1];
            v_q     <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign acc      = acc_q;
  assign acc_hi   = hi_q;
  assign c        = c_q;
  assign z        = z_q;
  assign n        = n_q;
  assign v        = v_q;
  assign done     = done_q;
  assign illegal  = ill_q;

endmodule
